exp_align_ctrl: RTL and testbench



---
 rtl/exp_align_ctrl.sv | 143 ++++++++++++++
 tb/tb_exp_align_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_align_ctrl.sv
`timescale 1ns/1ps
// Exponent alignment controller: pipelined max-exponent tree plus per-element
// right-shift computation, feeding sign/mantissa and shift vectors to the aligner.
module exp_align_ctrl #(
  parameter int MACRO_DATA_WIDTH = 128,
  parameter int SIGN_WIDTH       = 1,
  parameter int MANTISSA_WIDTH   = 3,
  parameter int EXP_WIDTH        = 4,
  parameter int LEVELS_PER_STAGE = 2
) (
  input  logic                                                          clk,
  input  logic                                                          rst_n,
  input  logic [MACRO_DATA_WIDTH*(SIGN_WIDTH+EXP_WIDTH+MANTISSA_WIDTH)-1:0] fp_data,
  input  logic                                                          fp_data_vld,
  output logic                                                          fp_data_rdy,
  output logic [MACRO_DATA_WIDTH*(SIGN_WIDTH+MANTISSA_WIDTH)-1:0]       mantissa,
  output logic                                                          mantissa_vld,
  input  logic                                                          mantissa_rdy,
  output logic [EXP_WIDTH*MACRO_DATA_WIDTH-1:0]                         shift,
  output logic                                                          shift_vld,
  input  logic                                                          shift_rdy,
  output logic [EXP_WIDTH-1:0]                                          max_exp
);

  localparam int N   = MACRO_DATA_WIDTH;
  localparam int EW  = EXP_WIDTH;
  localparam int MW  = MANTISSA_WIDTH;
  localparam int SW  = SIGN_WIDTH;
  localparam int SMW = SIGN_WIDTH + MANTISSA_WIDTH;
  localparam int W   = SIGN_WIDTH + EXP_WIDTH + MANTISSA_WIDTH;
  localparam int LPS = LEVELS_PER_STAGE;
  localparam int L   = $clog2(N);
  localparam int NT  = (L + LPS - 1) / LPS;

  function automatic logic [EW-1:0] umax(input logic [EW-1:0] a, input logic [EW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [N*W-1:0]   fp_p0;
  logic             vld_p0;
  logic [N*EW-1:0]  exp_p0;
  logic [N*SMW-1:0] sm_p0;

  logic [EW-1:0]    lvl      [0:L][N];
  logic [EW-1:0]    tree_nxt [1:NT][N];
  logic [EW-1:0]    max_p    [1:NT][N];
  logic [N*EW-1:0]  exp_p    [1:NT];
  logic [N*SMW-1:0] sm_p     [1:NT];
  logic [NT:1]      vld_p;

  logic [N*EW-1:0]  shift_nxt;
  logic [N*SMW-1:0] sm_out;
  logic [N*EW-1:0]  shift_out;
  logic [EW-1:0]    max_out;
  logic             vld_out;
  logic             stall;

  assign stall        = vld_out & ~(mantissa_rdy & shift_rdy);
  assign fp_data_rdy  = ~stall;
  assign mantissa     = sm_out;
  assign shift        = shift_out;
  assign max_exp      = max_out;
  assign mantissa_vld = vld_out;
  assign shift_vld    = vld_out;

  // Stage p0 -> tree: split each element into exponent and {sign, mantissa}
  always_comb begin
    exp_p0 = '0;
    sm_p0  = '0;
    for (int i = 0; i < N; i++) begin
      exp_p0[i*EW +: EW]  = fp_p0[i*W + MW +: EW];
      sm_p0[i*SMW +: SMW] = {fp_p0[i*W + MW + EW +: SW], fp_p0[i*W +: MW]};
    end
  end

  // Tree stages: levels grouped LPS at a time; the first level of each group
  // reads the previous group's register instead of the combinational level.
  always_comb begin
    for (int k = 0; k <= L; k++)
      for (int i = 0; i < N; i++)
        lvl[k][i] = '0;
    for (int s = 1; s <= NT; s++)
      for (int i = 0; i < N; i++)
        tree_nxt[s][i] = '0;
    for (int i = 0; i < N; i++)
      lvl[0][i] = exp_p0[i*EW +: EW];
    for (int k = 1; k <= L; k++) begin
      for (int i = 0; i < (N >> k); i++) begin
        if (k > 1 && ((k - 1) % LPS) == 0)
          lvl[k][i] = umax(max_p[(k-1)/LPS][2*i], max_p[(k-1)/LPS][2*i+1]);
        else
          lvl[k][i] = umax(lvl[k-1][2*i], lvl[k-1][2*i+1]);
      end
      if ((k % LPS) == 0 || k == L)
        for (int i = 0; i < N; i++)
          tree_nxt[(k-1)/LPS + 1][i] = lvl[k][i];
    end
  end

  // Output stage: shift never underflows since the tree root bounds every exponent
  always_comb begin
    shift_nxt = '0;
    for (int i = 0; i < N; i++)
      shift_nxt[i*EW +: EW] = max_p[NT][0] - exp_p[NT][i*EW +: EW];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fp_p0     <= '0;
      vld_p0    <= 1'b0;
      vld_p     <= '0;
      sm_out    <= '0;
      shift_out <= '0;
      max_out   <= '0;
      vld_out   <= 1'b0;
      for (int s = 1; s <= NT; s++) begin
        exp_p[s] <= '0;
        sm_p[s]  <= '0;
        for (int i = 0; i < N; i++)
          max_p[s][i] <= '0;
      end
    end else if (!stall) begin
      fp_p0    <= fp_data;
      vld_p0   <= fp_data_vld;
      vld_p[1] <= vld_p0;
      exp_p[1] <= exp_p0;
      sm_p[1]  <= sm_p0;
      for (int s = 2; s <= NT; s++) begin
        vld_p[s] <= vld_p[s-1];
        exp_p[s] <= exp_p[s-1];
        sm_p[s]  <= sm_p[s-1];
      end
      for (int s = 1; s <= NT; s++)
        for (int i = 0; i < N; i++)
          max_p[s][i] <= tree_nxt[s][i];
      sm_out    <= sm_p[NT];
      shift_out <= shift_nxt;
      max_out   <= max_p[NT][0];
      vld_out   <= vld_p[NT];
    end
  end

endmodule

// File: tb/tb_exp_align_ctrl.sv
`timescale 1ns/1ps
// Bench for exp_align_ctrl: directed and random vectors checked every cycle
// against an arithmetic max/subtract model with an in-order scoreboard.
module tb_exp_align_ctrl;

  localparam int N = 128, SW = 1, MW = 3, EW = 4, LPS = 2;
  localparam int W = SW + EW + MW, SMW = SW + MW;
  localparam int IW = N * W, SMV = N * SMW, SHV = N * EW;
  localparam int L = $clog2(N);
  localparam int NSTAGE = 1 + (L + LPS - 1) / LPS + 1;
  localparam int CW = 512;

  logic           clk, rst_n;
  logic [IW-1:0]  fp_data;
  logic           fp_data_vld, fp_data_rdy;
  logic [SMV-1:0] mantissa;
  logic           mantissa_vld, mantissa_rdy;
  logic [SHV-1:0] shift;
  logic           shift_vld, shift_rdy;
  logic [EW-1:0]  max_exp;

  exp_align_ctrl #(
    .MACRO_DATA_WIDTH(N), .SIGN_WIDTH(SW), .MANTISSA_WIDTH(MW),
    .EXP_WIDTH(EW), .LEVELS_PER_STAGE(LPS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fp_data(fp_data), .fp_data_vld(fp_data_vld), .fp_data_rdy(fp_data_rdy),
    .mantissa(mantissa), .mantissa_vld(mantissa_vld), .mantissa_rdy(mantissa_rdy),
    .shift(shift), .shift_vld(shift_vld), .shift_rdy(shift_rdy),
    .max_exp(max_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [SMV-1:0] sm;
    logic [SHV-1:0] sh;
    logic [EW-1:0]  mx;
    int             acc_cyc;
    int             acc_stall;
  } exp_t;

  exp_t q[$];
  int   log_mx[$];
  int   checks = 0, errors = 0, cyc = 0, stall_cnt = 0;
  bit   armed = 0, zero_chk = 0, seen = 0;

  task automatic chk(input bit ok, input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [IW-1:0] v);
    exp_t e;
    logic [EW-1:0] ex [N];
    e.mx = '0;
    e.sm = '0;
    e.sh = '0;
    for (int i = 0; i < N; i++) begin
      ex[i] = v[i*W + MW +: EW];
      if (ex[i] > e.mx) e.mx = ex[i];
      e.sm[i*SMW +: SMW] = {v[i*W + MW + EW +: SW], v[i*W +: MW]};
    end
    for (int i = 0; i < N; i++)
      e.sh[i*EW +: EW] = e.mx - ex[i];
    e.acc_cyc = 0;
    e.acc_stall = 0;
    return e;
  endfunction

  // Per-cycle compare against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    bit out_rdy;
    cyc++;
    out_rdy = mantissa_rdy & shift_rdy;
    if (armed) begin
      chk(mantissa_vld === shift_vld, "vld_equal", CW'(mantissa_vld), CW'(shift_vld));
      if (zero_chk) begin
        chk(mantissa_vld === 1'b0, "rst_vld", CW'(mantissa_vld), CW'(0));
        chk(mantissa === '0 && shift === '0 && max_exp === '0, "rst_data",
            CW'(max_exp), CW'(0));
        chk(fp_data_rdy === 1'b1, "rst_rdy", CW'(fp_data_rdy), CW'(1));
        zero_chk = 0;
      end
      if (mantissa_vld === 1'b1) begin
        if (q.size() == 0) begin
          chk(1'b0, "spurious_output", CW'(max_exp), CW'(0));
        end else begin
          e = q[0];
          chk(mantissa === e.sm, "mantissa", CW'(mantissa), CW'(e.sm));
          chk(shift === e.sh, "shift", CW'(shift), CW'(e.sh));
          chk(max_exp === e.mx, "max_exp", CW'(max_exp), CW'(e.mx));
          if (!seen) begin
            chk(cyc - e.acc_cyc == NSTAGE + (stall_cnt - e.acc_stall), "latency",
                CW'(cyc - e.acc_cyc), CW'(NSTAGE + (stall_cnt - e.acc_stall)));
            seen = 1;
          end
          if (out_rdy) begin
            log_mx.push_back(int'(e.mx));
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
      chk(fp_data_rdy === !(mantissa_vld && !out_rdy), "in_rdy",
          CW'(fp_data_rdy), CW'(!(mantissa_vld && !out_rdy)));
      if (mantissa_vld && !out_rdy) stall_cnt++;
    end
    if (!rst_n) begin
      q.delete();
      armed = 1;
      zero_chk = 1;
      seen = 0;
    end else if (armed && fp_data_vld && fp_data_rdy) begin
      e = model(fp_data);
      e.acc_cyc = cyc;
      e.acc_stall = stall_cnt;
      q.push_back(e);
    end
  end

  function automatic logic [IW-1:0] rand_vec();
    logic [IW-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  function automatic logic [IW-1:0] put_exp(input logic [IW-1:0] v, input int i, input logic [EW-1:0] e);
    v[i*W + MW +: EW] = e;
    return v;
  endfunction

  function automatic logic [EW-1:0] sh_el(input int i);
    return shift[i*EW +: EW];
  endfunction

  task automatic send(input logic [IW-1:0] v, output bit first_try);
    bit acc;
    int tries;
    fp_data = v;
    fp_data_vld = 1'b1;
    tries = 0;
    do begin
      @(negedge clk);
      acc = fp_data_rdy;
      @(posedge clk);
      #2;
      tries++;
    end while (!acc && tries < 100);
    if (!acc) chk(1'b0, "send_timeout", CW'(tries), CW'(100));
    first_try = (tries == 1);
    fp_data_vld = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mantissa_vld !== 1'b1 && n < 60);
    if (mantissa_vld !== 1'b1) chk(1'b0, "wait_out_timeout", CW'(n), CW'(60));
  endtask

  task automatic drain();
    int n;
    n = 0;
    mantissa_rdy = 1'b1;
    shift_rdy = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while ((q.size() != 0 || mantissa_vld === 1'b1) && n < 300);
    if (q.size() != 0) chk(1'b0, "drain_timeout", CW'(q.size()), CW'(0));
  endtask

  initial begin
    logic [IW-1:0] v;
    bit ok;
    int pos_list [3];
    int maxe, mi;
    pos_list = '{127, 0, 64};
    rst_n = 1'b0; fp_data = '0; fp_data_vld = 1'b0;
    mantissa_rdy = 1'b1; shift_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // All exponents equal
    v = rand_vec();
    for (int i = 0; i < N; i++) v = put_exp(v, i, 4'd7);
    send(v, ok);
    wait_out();
    chk(max_exp == 4'd7, "eq_max", CW'(max_exp), CW'(7));
    chk(shift == '0, "eq_shift", CW'(shift), CW'(0));
    @(negedge clk);
    chk(mantissa_vld == 1'b0, "eq_one_cycle", CW'(mantissa_vld), CW'(0));

    // Single maximum at the last, first and middle element
    for (int p = 0; p < 3; p++) begin
      v = rand_vec();
      for (int i = 0; i < N; i++) v = put_exp(v, i, 4'd0);
      v = put_exp(v, pos_list[p], 4'd15);
      @(posedge clk); #2;
      send(v, ok);
      wait_out();
      chk(max_exp == 4'd15, "single_max", CW'(max_exp), CW'(15));
      chk(sh_el(pos_list[p]) == 4'd0, "single_shift_at_max", CW'(sh_el(pos_list[p])), CW'(0));
      chk(sh_el((pos_list[p] + 1) % N) == 4'd15, "single_shift_other",
          CW'(sh_el((pos_list[p] + 1) % N)), CW'(15));
    end

    // Ramp exponents
    v = rand_vec();
    for (int i = 0; i < N; i++) v = put_exp(v, i, EW'(i % 16));
    @(posedge clk); #2;
    send(v, ok);
    wait_out();
    chk(max_exp == 4'd15, "ramp_max", CW'(max_exp), CW'(15));
    chk(sh_el(5) == 4'd10, "ramp_shift5", CW'(sh_el(5)), CW'(10));
    chk(sh_el(16) == 4'd15, "ramp_shift16", CW'(sh_el(16)), CW'(15));
    chk(sh_el(127) == 4'd0, "ramp_shift127", CW'(sh_el(127)), CW'(0));
    drain();

    // Ten back-to-back vectors, maxima 0..9
    log_mx.delete();
    @(posedge clk); #2;
    for (int m = 0; m < 10; m++) begin
      v = rand_vec();
      for (int i = 0; i < N; i++) v = put_exp(v, i, EW'($urandom_range(0, m)));
      v = put_exp(v, $urandom_range(0, N - 1), EW'(m));
      send(v, ok);
      chk(ok, "b2b_rdy", CW'(ok), CW'(1));
    end
    drain();
    chk(log_mx.size() == 10, "b2b_count", CW'(log_mx.size()), CW'(10));
    for (int k = 0; k < 10 && k < log_mx.size(); k++)
      chk(log_mx[k] == k, "b2b_order", CW'(log_mx[k]), CW'(k));

    // Backpressure from each downstream ready in turn
    for (int which = 0; which < 2; which++) begin
      @(posedge clk); #2;
      if (which == 0) shift_rdy = 1'b0; else mantissa_rdy = 1'b0;
      v = rand_vec();
      for (int i = 0; i < N; i++) v = put_exp(v, i, 4'd3);
      v = put_exp(v, 10, 4'd12);
      send(v, ok);
      v = rand_vec();
      for (int i = 0; i < N; i++) v = put_exp(v, i, 4'd5);
      send(v, ok);
      wait_out();
      for (int j = 0; j < 4; j++) begin
        if (j > 0) @(negedge clk);
        chk(mantissa_vld == 1'b1, "bp_hold_vld", CW'(mantissa_vld), CW'(1));
        chk(max_exp == 4'd12, "bp_hold_max", CW'(max_exp), CW'(12));
        chk(fp_data_rdy == 1'b0, "bp_in_rdy", CW'(fp_data_rdy), CW'(0));
      end
      @(posedge clk); #2;
      drain();
    end

    // Reset with three vectors in flight
    @(posedge clk); #2;
    for (int k = 0; k < 3; k++) begin
      v = rand_vec();
      for (int i = 0; i < N; i++) v = put_exp(v, i, EW'($urandom_range(0, 15)));
      send(v, ok);
    end
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    @(posedge clk); #2;
    v = rand_vec();
    for (int i = 0; i < N; i++) v = put_exp(v, i, 4'd2);
    v = put_exp(v, 77, 4'd9);
    send(v, ok);
    wait_out();
    chk(max_exp == 4'd9, "post_rst_max", CW'(max_exp), CW'(9));
    chk(sh_el(0) == 4'd7, "post_rst_shift", CW'(sh_el(0)), CW'(7));
    drain();

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #2;
      maxe = $urandom_range(0, 15);
      v = rand_vec();
      for (int i = 0; i < N; i++) v = put_exp(v, i, EW'($urandom_range(0, maxe)));
      mi = $urandom_range(0, N - 1);
      v = put_exp(v, mi, EW'(maxe));
      fp_data = v;
      fp_data_vld = ($urandom_range(0, 3) != 0);
      mantissa_rdy = ($urandom_range(0, 3) != 0);
      shift_rdy = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #2;
    fp_data_vld = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
